// File: rtl/qu_common_pkg.sv
// Shared widths for the Qu core datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: DATA_WIDTH, RS_TAG_WIDTH.
package qu_common;
  localparam int DATA_WIDTH   = 32;
  localparam int RS_TAG_WIDTH = 4;
endpackage

// File: rtl/qu_uop_pkg.sv
// Micro-op encoding: reservation-station cell layout and function codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: res_st_cell_t, FN_* codes, op field slice positions.
package qu_uop;
  import qu_common::*;

  localparam int OP_WIDTH   = 14;
  localparam int OP_FUNC_HI = 13;
  localparam int OP_FUNC_LO = 9;

  typedef struct packed {
    logic                    busy;
    logic [OP_WIDTH-1:0]     op;
    logic [RS_TAG_WIDTH-1:0] qj;
    logic [RS_TAG_WIDTH-1:0] qk;
    logic [DATA_WIDTH-1:0]   vj;
    logic [DATA_WIDTH-1:0]   vk;
    logic [DATA_WIDTH-1:0]   a;
  } res_st_cell_t;

  // ALU codes
  localparam logic [4:0] FN_ADD    = 5'b00000;
  localparam logic [4:0] FN_SLL    = 5'b00001;
  localparam logic [4:0] FN_SLT    = 5'b00010;
  localparam logic [4:0] FN_SLTU   = 5'b00011;
  localparam logic [4:0] FN_XOR    = 5'b00100;
  localparam logic [4:0] FN_SRL    = 5'b00101;
  localparam logic [4:0] FN_OR     = 5'b00110;
  localparam logic [4:0] FN_AND    = 5'b00111;
  localparam logic [4:0] FN_SRA    = 5'b01101;
  localparam logic [4:0] FN_SUB    = 5'b01111;
  // Branch codes
  localparam logic [4:0] FN_BEQ    = 5'b10000;
  localparam logic [4:0] FN_BNE    = 5'b10001;
  localparam logic [4:0] FN_BLT    = 5'b10100;
  localparam logic [4:0] FN_BGE    = 5'b10101;
  localparam logic [4:0] FN_BLTU   = 5'b10110;
  localparam logic [4:0] FN_BGEU   = 5'b10111;
  // Multiply codes (only decoded when QU_EXEC_MUL_EN is defined)
  localparam logic [4:0] FN_MUL    = 5'b11000;
  localparam logic [4:0] FN_MULH   = 5'b11001;
  localparam logic [4:0] FN_MULHSU = 5'b11010;
  localparam logic [4:0] FN_MULHU  = 5'b11011;
endpackage

// File: rtl/qu_alu.sv
// Combinational integer ALU and branch comparator for the execute stage.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output tracks inputs.
// Ports: func (5b code), a/b operands -> result (32b), cmp (branch outcome).
// Optional: QU_EXEC_MUL_EN adds MUL/MULH/MULHSU/MULHU; otherwise those codes yield 0.
module qu_alu
  import qu_common::*;
  import qu_uop::*;
(
  input  logic [4:0]            func,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  cmp
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

`ifdef QU_EXEC_MUL_EN
  // Low 64 bits of a 64x64 product of extended operands equal the exact
  // 32x32 product for each signedness combination.
  logic [63:0] prod_ss;
  logic [63:0] prod_su;
  logic [63:0] prod_uu;
  assign prod_ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_su = {{32{a[31]}}, a} * {32'b0, b};
  assign prod_uu = {32'b0, a} * {32'b0, b};
`endif

  always_comb begin
    result = '0;
    cmp    = 1'b0;
    case (func)
      FN_ADD:    result = a + b;
      FN_SUB:    result = a - b;
      FN_SLL:    result = a << shamt;
      FN_SRL:    result = a >> shamt;
      FN_SRA:    result = $signed(a) >>> shamt;
      FN_SLT:    result = {31'b0, lt_s};
      FN_SLTU:   result = {31'b0, lt_u};
      FN_XOR:    result = a ^ b;
      FN_OR:     result = a | b;
      FN_AND:    result = a & b;
      FN_BEQ:    cmp = (a == b);
      FN_BNE:    cmp = (a != b);
      FN_BLT:    cmp = lt_s;
      FN_BGE:    cmp = !lt_s;
      FN_BLTU:   cmp = lt_u;
      FN_BGEU:   cmp = !lt_u;
`ifdef QU_EXEC_MUL_EN
      FN_MUL:    result = prod_uu[31:0];
      FN_MULH:   result = prod_ss[63:32];
      FN_MULHSU: result = prod_su[63:32];
      FN_MULHU:  result = prod_uu[63:32];
`endif
      default: begin
        result = '0;
        cmp    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/qu_execute.sv
// Single-cycle integer execute stage: ALU/branch result plus registered copy of the cell.
// Latency: 1 cycle (inputs sampled at edge N are visible after edge N).
// Backpressure: none; consumer must accept one result every cycle.
// Ports: clk, rst_n (sync, active-low), op_in (issued cell) -> value_out, comp_result, op_out.
// Optional: QU_EXEC_MUL_EN enables the RV32M multiply codes inside qu_alu.
module qu_execute
  import qu_common::*;
  import qu_uop::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  res_st_cell_t          op_in,
  output logic [DATA_WIDTH-1:0] value_out,
  output logic                  comp_result,
  output res_st_cell_t          op_out
);

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_cmp;

  qu_alu u_alu (
    .func   (op_in.op[OP_FUNC_HI:OP_FUNC_LO]),
    .a      (op_in.vj),
    .b      (op_in.vk),
    .result (alu_result),
    .cmp    (alu_cmp)
  );

  // A bubble (busy = 0) clears every output so downstream never sees stale
  // fields from an empty cell.
  always_ff @(posedge clk) begin
    if (!rst_n || !op_in.busy) begin
      value_out   <= '0;
      comp_result <= 1'b0;
      op_out      <= '0;
    end else begin
      value_out   <= alu_result;
      comp_result <= alu_cmp;
      op_out      <= op_in;
    end
  end

endmodule

// File: tb/tb_qu_execute.sv
module tb_qu_execute;
  import qu_common::*;
  import qu_uop::*;

  logic                  clk;
  logic                  rst_n;
  res_st_cell_t          op_in;
  logic [DATA_WIDTH-1:0] value_out;
  logic                  comp_result;
  res_st_cell_t          op_out;

  int n_pass  = 0;
  int n_total = 0;

  qu_execute dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_in       (op_in),
    .value_out   (value_out),
    .comp_result (comp_result),
    .op_out      (op_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_st_cell_t mk(input logic [4:0] fn, input logic [8:0] rsv,
                                      input logic [31:0] vj, input logic [31:0] vk);
    res_st_cell_t c;
    c.busy = 1'b1;
    c.op   = {fn, rsv};
    c.qj   = '0;
    c.qk   = '0;
    c.vj   = vj;
    c.vk   = vk;
    c.a    = 32'hA5A5_0000 ^ vj;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a cell, let one rising edge capture it, sample 1 time unit later.
  task automatic issue(input res_st_cell_t c);
    op_in = c;
    @(posedge clk);
    #1;
  endtask

  res_st_cell_t c, c2, c3;
  res_st_cell_t zero_cell;

  initial begin
    zero_cell = '0;
    rst_n = 1'b0;
    // Live op held during reset must be discarded.
    op_in = mk(FN_ADD, 9'h0, 32'd5, 32'd10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_value", {96'b0, value_out}, 128'd0);
    chk("rst_cmp", {127'b0, comp_result}, 128'd0);
    chk("rst_op_out", {9'b0, op_out}, {9'b0, zero_cell});
    chk("rst_busy", {127'b0, op_out.busy}, 128'd0);
    rst_n = 1'b1;

    // ADD with op = 0
    c = mk(FN_ADD, 9'h0, 32'd5, 32'd10);
    issue(c);
    chk("add_value", {96'b0, value_out}, 128'd15);
    chk("add_cmp", {127'b0, comp_result}, 128'd0);
    chk("add_op_out", {9'b0, op_out}, {9'b0, c});

    // SUB then wrap; reserved op bits must pass through
    c = mk(FN_SUB, 9'h0, 32'd20, 32'd10);
    issue(c);
    chk("sub_value", {96'b0, value_out}, 128'd10);
    c = mk(FN_SUB, 9'h1A5, 32'd0, 32'd1);
    issue(c);
    chk("sub_wrap", {96'b0, value_out}, {96'b0, 32'hFFFF_FFFF});
    chk("sub_rsv_pass", {114'b0, op_out.op}, {114'b0, 5'b01111, 9'h1A5});

    // Branches
    issue(mk(FN_BLT, 9'h0, 32'hFFFF_FFFF, 32'd1));
    chk("blt_cmp", {127'b0, comp_result}, 128'd1);
    chk("blt_value", {96'b0, value_out}, 128'd0);
    issue(mk(FN_BLTU, 9'h0, 32'hFFFF_FFFF, 32'd1));
    chk("bltu_cmp", {127'b0, comp_result}, 128'd0);
    issue(mk(FN_BEQ, 9'h0, 32'd7, 32'd7));
    chk("beq_cmp", {127'b0, comp_result}, 128'd1);
    issue(mk(FN_BGEU, 9'h0, 32'hFFFF_FFFF, 32'd1));
    chk("bgeu_cmp", {127'b0, comp_result}, 128'd1);
    issue(mk(FN_BNE, 9'h0, 32'd7, 32'd7));
    chk("bne_cmp", {127'b0, comp_result}, 128'd0);

    // Other ALU codes
    issue(mk(FN_SLT, 9'h0, 32'hFFFF_FFFE, 32'd3));
    chk("slt_value", {96'b0, value_out}, 128'd1);
    issue(mk(FN_SLL, 9'h0, 32'h0000_0003, 32'h0000_0024));
    chk("sll_value", {96'b0, value_out}, {96'b0, 32'h0000_0030});
    issue(mk(FN_XOR, 9'h0, 32'hF0F0_1234, 32'h0FF0_FFFF));
    chk("xor_value", {96'b0, value_out}, {96'b0, 32'hFF00_EDCB});

    // ADD, bubble, SRA back-to-back
    c  = mk(FN_ADD, 9'h0, 32'd1, 32'd2);
    c2 = mk(FN_ADD, 9'h0, 32'd9, 32'd9);
    c2.busy = 1'b0;
    c3 = mk(FN_SRA, 9'h0, 32'h8000_0000, 32'd4);
    issue(c);
    chk("b2b_add", {96'b0, value_out}, 128'd3);
    issue(c2);
    chk("b2b_bubble_value", {96'b0, value_out}, 128'd0);
    chk("b2b_bubble_op", {9'b0, op_out}, {9'b0, zero_cell});
    issue(c3);
    chk("b2b_sra", {96'b0, value_out}, {96'b0, 32'hF800_0000});
    chk("b2b_sra_op", {9'b0, op_out}, {9'b0, c3});

    // Multiply code
    c = mk(FN_MUL, 9'h0, 32'd6, 32'd7);
    issue(c);
`ifdef QU_EXEC_MUL_EN
    chk("mul_value", {96'b0, value_out}, 128'd42);
    issue(mk(FN_MULHU, 9'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    chk("mulhu_value", {96'b0, value_out}, {96'b0, 32'hFFFF_FFFE});
    issue(mk(FN_MULH, 9'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    chk("mulh_value", {96'b0, value_out}, 128'd0);
`else
    chk("mul_value", {96'b0, value_out}, 128'd0);
    chk("mul_op_out", {9'b0, op_out}, {9'b0, c});
`endif

    // Unassigned code still passes the cell through
    c = mk(5'b11111, 9'h055, 32'd6, 32'd7);
    issue(c);
    chk("unassigned_value", {96'b0, value_out}, 128'd0);
    chk("unassigned_cmp", {127'b0, comp_result}, 128'd0);
    chk("unassigned_op", {9'b0, op_out}, {9'b0, c});

    // Reset while an op is in flight discards it
    op_in = mk(FN_ADD, 9'h0, 32'd100, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_value", {96'b0, value_out}, 128'd0);
    chk("midrst_busy", {127'b0, op_out.busy}, 128'd0);
    rst_n = 1'b1;
    issue(mk(FN_OR, 9'h0, 32'h0000_00F0, 32'h0000_000F));
    chk("post_rst_or", {96'b0, value_out}, {96'b0, 32'h0000_00FF});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
